sd_sample_player: RTL

- Consumer end of the sample FIFO filled by the SD driver.
- On a note-on it requests a sample stream from the driver.
- Pops one 16-bit signed sample per sample_tick, scales it by note velocity and presents it to the mixer.
- Handles priming, underrun, natural end of stream and note-off flush.

---
 rtl/sd_pkg.sv | 24 ++
 rtl/sd_sample_scaler.sv | 82 ++++++++
 rtl/sd_sample_player.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: definitions shared by the SD sample player and its scaler.
//   - SD driver state codes as seen on drv_state
//   - player FSM state encoding (3 bits)
//   - default sample and velocity widths
package sd_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int VEL_W_DEF    = 7;

    localparam logic [2:0] DRV_IDLE        = 3'b000;
    localparam logic [2:0] DRV_BOOT        = 3'b001;
    localparam logic [2:0] DRV_FETCH       = 3'b010;
    localparam logic [2:0] DRV_WAIT        = 3'b011;
    localparam logic [2:0] DRV_FIRST_FETCH = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_PRIME = 3'd2,
        ST_PLAY  = 3'd3,
        ST_FLUSH = 3'd4
    } player_state_t;

endpackage

// File: rtl/sd_sample_scaler.sv
// sd_sample_scaler: velocity scaling pipeline behind the FIFO pop.
//   in_valid  pop/underrun strobe, same cycle as fifo_rd (T)
//   in_zero   the strobe is an underrun: scale a zero instead of FIFO data
//   flush     kills everything in flight (no output while flushing)
//   velocity  latched note velocity
//   fifo_dout FIFO data, valid the cycle after the pop (T+1)
//   out_sample/out_valid  scaled sample, one-cycle strobe registered at T+2
module sd_sample_scaler
    import sd_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int VEL_W    = VEL_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_zero,
    input  logic                flush,
    input  logic [VEL_W-1:0]    velocity,
    input  logic [SAMPLE_W-1:0] fifo_dout,
    output logic [SAMPLE_W-1:0] out_sample,
    output logic                out_valid
);

    localparam int PROD_W = SAMPLE_W + VEL_W + 1;

    logic                pend_q, pend_d;
    logic                pend_zero_q, pend_zero_d;
    logic                cap_valid_q, cap_valid_d;
    logic [SAMPLE_W-1:0] cap_sample_q, cap_sample_d;
    logic                out_valid_q, out_valid_d;
    logic [SAMPLE_W-1:0] out_sample_q, out_sample_d;

    logic [VEL_W:0]            vel_p1;
    logic signed [PROD_W-1:0]  sample_ext;
    logic signed [PROD_W-1:0]  vel_ext;
    logic signed [PROD_W-1:0]  prod;

    always_comb begin
        pend_d       = in_valid & ~flush;
        pend_zero_d  = in_zero;
        cap_valid_d  = pend_q & ~flush;
        cap_sample_d = cap_sample_q;
        if (pend_q) begin
            cap_sample_d = pend_zero_q ? '0 : fifo_dout;
        end

        // (velocity+1) is at most 2**VEL_W, so the product always fits PROD_W
        vel_p1     = {1'b0, velocity} + {{VEL_W{1'b0}}, 1'b1};
        sample_ext = {{(VEL_W + 1){cap_sample_q[SAMPLE_W-1]}}, cap_sample_q};
        vel_ext    = {{SAMPLE_W{1'b0}}, vel_p1};
        prod       = sample_ext * vel_ext;

        out_valid_d  = cap_valid_q & ~flush;
        out_sample_d = out_sample_q;
        if (cap_valid_q) begin
            out_sample_d = SAMPLE_W'(prod >>> VEL_W);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q       <= 1'b0;
            pend_zero_q  <= 1'b0;
            cap_valid_q  <= 1'b0;
            cap_sample_q <= '0;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
        end else begin
            pend_q       <= pend_d;
            pend_zero_q  <= pend_zero_d;
            cap_valid_q  <= cap_valid_d;
            cap_sample_q <= cap_sample_d;
            out_valid_q  <= out_valid_d;
            out_sample_q <= out_sample_d;
        end
    end

    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;

endmodule

// File: rtl/sd_sample_player.sv
// sd_sample_player: consumer end of the SD sample FIFO.
// On note_on it requests a stream from the SD driver (drv_start level), waits
// for data, then pops one sample per sample_tick, scales it by velocity and
// strobes it to the mixer. Handles underrun (zero output, saturating count),
// end of stream and note-off flush (drv_stop level, FIFO drained).
// Ports: clk/rst; note_on/note_off/sample_code_in/velocity from the voice
// allocator; sample_tick audio-rate pulse; drv_state/drv_start/drv_stop/
// drv_sample_code to the driver; fifo_empty/fifo_dout/fifo_rd to the FIFO;
// audio_out/audio_valid to the mixer; busy and underrun_cnt status.
// Optional build macro SP_RETRIGGER_EN: note_on while active flushes and
// re-arms with the new sample code and velocity.
module sd_sample_player
    import sd_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int VEL_W      = VEL_W_DEF,
    parameter int UNDERRUN_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  note_on,
    input  logic                  note_off,
    input  logic [7:0]            sample_code_in,
    input  logic [VEL_W-1:0]      velocity,
    input  logic                  sample_tick,
    input  logic [2:0]            drv_state,
    output logic                  drv_start,
    output logic                  drv_stop,
    output logic [7:0]            drv_sample_code,
    input  logic                  fifo_empty,
    input  logic [SAMPLE_W-1:0]   fifo_dout,
    output logic                  fifo_rd,
    output logic [SAMPLE_W-1:0]   audio_out,
    output logic                  audio_valid,
    output logic                  busy,
    output logic [UNDERRUN_W-1:0] underrun_cnt
);

    player_state_t         state_q, state_d;
    logic [7:0]            code_q, code_d;
    logic [VEL_W-1:0]      vel_q, vel_d;
    logic [UNDERRUN_W-1:0] ucnt_q, ucnt_d;
    logic                  scl_valid;
    logic                  scl_zero;
`ifdef SP_RETRIGGER_EN
    logic                  retrig_q, retrig_d;
`endif

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        vel_d     = vel_q;
        ucnt_d    = ucnt_q;
        fifo_rd   = 1'b0;
        scl_valid = 1'b0;
        scl_zero  = 1'b0;
        drv_start = (state_q == ST_ARM);
        drv_stop  = (state_q == ST_FLUSH);
`ifdef SP_RETRIGGER_EN
        retrig_d  = retrig_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (note_on && !note_off) begin
                    code_d  = sample_code_in;
                    vel_d   = velocity;
                    ucnt_d  = '0;
                    state_d = ST_ARM;
                end
            end
            ST_ARM, ST_PRIME, ST_PLAY: begin
                // note_off outranks both retrigger and a same-cycle tick
                if (note_off) begin
                    state_d = ST_FLUSH;
                end
`ifdef SP_RETRIGGER_EN
                else if (note_on) begin
                    code_d   = sample_code_in;
                    vel_d    = velocity;
                    retrig_d = 1'b1;
                    state_d  = ST_FLUSH;
                end
`endif
                else if (state_q == ST_ARM) begin
                    if (drv_state != DRV_IDLE) state_d = ST_PRIME;
                end else if (state_q == ST_PRIME) begin
                    if (!fifo_empty)                 state_d = ST_PLAY;
                    else if (drv_state == DRV_IDLE)  state_d = ST_IDLE;
                end else if (sample_tick) begin
                    if (!fifo_empty) begin
                        fifo_rd   = 1'b1;
                        scl_valid = 1'b1;
                    end else if (drv_state != DRV_IDLE) begin
                        scl_valid = 1'b1;
                        scl_zero  = 1'b1;
                        if (ucnt_q != '1) ucnt_d = ucnt_q + UNDERRUN_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                fifo_rd = !fifo_empty;
`ifdef SP_RETRIGGER_EN
                if (note_off) retrig_d = 1'b0;
`endif
                if (fifo_empty && drv_state == DRV_IDLE) begin
`ifdef SP_RETRIGGER_EN
                    if (retrig_d) begin
                        retrig_d = 1'b0;
                        ucnt_d   = '0;
                        state_d  = ST_ARM;
                    end else begin
                        state_d  = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            vel_q   <= '0;
            ucnt_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            vel_q   <= vel_d;
            ucnt_q  <= ucnt_d;
        end
    end

`ifdef SP_RETRIGGER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) retrig_q <= 1'b0;
        else     retrig_q <= retrig_d;
    end
`endif

    sd_sample_scaler #(
        .SAMPLE_W (SAMPLE_W),
        .VEL_W    (VEL_W)
    ) u_scaler (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (scl_valid),
        .in_zero    (scl_zero),
        .flush      (state_q == ST_FLUSH),
        .velocity   (vel_q),
        .fifo_dout  (fifo_dout),
        .out_sample (audio_out),
        .out_valid  (audio_valid)
    );

    assign drv_sample_code = code_q;
    assign busy            = (state_q != ST_IDLE);
    assign underrun_cnt    = ucnt_q;

endmodule
